// File: rtl/fadd_normalize_stage.sv
// Post-add normalization stage of the floating-point adder.
// Stage 1 registers the raw sum together with its leading-zero count, which
// comes from a tree of 4-bit priority encoders. Stage 2 shifts the mantissa
// into normalized form, adjusts the exponent and raises at most one of the
// zero / overflow / underflow flags. Both stages use a valid/ready handshake.
module fadd_normalize_stage #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24,
  parameter int SUM_W  = MANT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [SUM_W-1:0]  in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam int NUM_GRP = MANT_W / 4;
  localparam int LZ_W    = $clog2(MANT_W + 1);
  // Largest biased exponent; reaching it on a carry means the result saturates.
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // Handshake and pipeline occupancy
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;
  logic in_fire;

  // Stage 1 registers
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic              s1_carry;
  logic [MANT_W-1:0] s1_mant;
  logic [LZ_W-1:0]   s1_lz;

  // Leading-zero tree
  logic [NUM_GRP-1:0]   grp_nz;
  logic [2*NUM_GRP-1:0] grp_pos;
  logic [LZ_W-1:0]      lz_raw;

  // Stage 2 next-state values
  logic              nxt_sign;
  logic [EXP_W-1:0]  nxt_exp;
  logic [MANT_W-1:0] nxt_mant;
  logic              nxt_zero;
  logic              nxt_overflow;
  logic              nxt_underflow;
  logic [EXP_W:0]    exp_wide;
  logic [EXP_W:0]    exp_inc;
  logic [EXP_W:0]    lz_wide;

  // Stage 1 moves forward whenever stage 2 is empty or being drained this cycle.
  // The upstream side may push whenever stage 1 is empty or is moving forward,
  // so in_ready is combinational from out_ready and a full pipe stalls cleanly.
  assign s1_advance = s1_valid & (~s2_valid | out_ready);
  assign in_ready   = ~s1_valid | ~s2_valid | out_ready;
  assign in_fire    = in_valid & in_ready;
  assign out_valid  = s2_valid;

  // Group 0 is the most significant nibble of the mantissa field; each nibble
  // gets its own priority encoder reporting "any one present" and the position
  // of its leading one.
  genvar g;
  generate
    for (g = 0; g < NUM_GRP; g++) begin : g_enc
      logic [3:0] nib;
      assign nib               = in_mant[MANT_W-1-4*g -: 4];
      assign grp_nz[g]         = |nib;
      assign grp_pos[2*g +: 2] = nib[3] ? 2'd0 :
                                 nib[2] ? 2'd1 :
                                 nib[1] ? 2'd2 : 2'd3;
    end
  endgenerate

  // Group select: the first non-empty nibble from the top sets the count;
  // an all-zero field reports the full mantissa width.
  always_comb begin
    lz_raw = LZ_W'(MANT_W);
    for (int i = NUM_GRP - 1; i >= 0; i--) begin
      if (grp_nz[i]) begin
        lz_raw = LZ_W'(4 * i) + LZ_W'(grp_pos[2*i +: 2]);
      end
    end
  end

  // Stage 1 captures the incoming sum and its leading-zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_carry <= 1'b0;
      s1_mant  <= '0;
      s1_lz    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_sign  <= in_sign;
      s1_exp   <= in_exp;
      s1_carry <= in_mant[SUM_W-1];
      s1_mant  <= in_mant[MANT_W-1:0];
      s1_lz    <= lz_raw;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Exponent work is done one bit wider so increments and comparisons never wrap.
  assign exp_wide = {1'b0, s1_exp};
  assign exp_inc  = exp_wide + (EXP_W + 1)'(1);
  assign lz_wide  = (EXP_W + 1)'(s1_lz);

  // Normalization cases in priority order: carry overflow, carry shift-right,
  // exact zero, underflow flush, then the ordinary left shift.
  always_comb begin
    nxt_sign      = s1_sign;
    nxt_exp       = '0;
    nxt_mant      = '0;
    nxt_zero      = 1'b0;
    nxt_overflow  = 1'b0;
    nxt_underflow = 1'b0;
    if (s1_carry && (exp_inc >= EXP_MAX)) begin
      nxt_exp      = '1;
      nxt_overflow = 1'b1;
    end else if (s1_carry) begin
      nxt_exp  = s1_exp + EXP_W'(1);
      nxt_mant = {s1_carry, s1_mant[MANT_W-1:1]};
    end else if (s1_mant == '0) begin
      nxt_zero = 1'b1;
      nxt_sign = 1'b0;
    end else if (exp_wide <= lz_wide) begin
      nxt_underflow = 1'b1;
    end else begin
      nxt_exp  = s1_exp - EXP_W'(s1_lz);
      nxt_mant = s1_mant << s1_lz;
    end
  end

  // Stage 2 is the output register; it holds its contents while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_mant      <= '0;
      out_zero      <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (s1_advance) begin
      s2_valid      <= 1'b1;
      out_sign      <= nxt_sign;
      out_exp       <= nxt_exp;
      out_mant      <= nxt_mant;
      out_zero      <= nxt_zero;
      out_overflow  <= nxt_overflow;
      out_underflow <= nxt_underflow;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule
